// File: rtl/model_dual_ram_be_if.sv
// Bus bundle for model_dual_ram_be: write port, read request port and read response.
// master drives requests, slave is the RAM.
interface model_dual_ram_be_if #(
    parameter int WIDTH     = 32,
    parameter int DEPTH_LOG = 8,
    parameter int BYTE_W    = 8
);
    localparam int NB = WIDTH / BYTE_W;

    logic                 ram_write_req;
    logic [DEPTH_LOG-1:0] ram_write_addr;
    logic [NB-1:0]        ram_write_be;
    logic [WIDTH-1:0]     ram_write_data;
    logic                 ram_read_req;
    logic [DEPTH_LOG-1:0] ram_read_addr;
    logic [WIDTH-1:0]     ram_read_data;
    logic                 ram_read_valid;

    modport master (
        output ram_write_req, ram_write_addr, ram_write_be, ram_write_data,
        output ram_read_req, ram_read_addr,
        input  ram_read_data, ram_read_valid
    );

    modport slave (
        input  ram_write_req, ram_write_addr, ram_write_be, ram_write_data,
        input  ram_read_req, ram_read_addr,
        output ram_read_data, ram_read_valid
    );
endinterface

// File: rtl/model_dual_ram_be.sv
// Simple dual-port RAM with byte-lane write enables, a registered write stage,
// read latency of 1 or 2 and optional forwarding of the pending write to a
// colliding read. The storage array itself is never reset.
module model_dual_ram_be #(
    parameter int WIDTH     = 32,
    parameter int DEPTH_LOG = 8,
    parameter int BYTE_W    = 8,
    parameter int OUT_REG   = 0,
    parameter int BYPASS    = 1
) (
    input logic                clk,
    input logic                rst_n,
    model_dual_ram_be_if.slave bus
);
    localparam int NB    = WIDTH / BYTE_W;
    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]     mem [DEPTH];

    logic                 wr_req_q;
    logic [DEPTH_LOG-1:0] wr_addr_q;
    logic [NB-1:0]        wr_be_q;
    logic [WIDTH-1:0]     wr_data_q;

    logic [WIDTH-1:0]     rd_word;
    logic                 rd_valid_q;
    logic [WIDTH-1:0]     rd_data_q;

    // Capture a write request; it commits to the array on the following edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_req_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
            wr_data_q <= '0;
        end else begin
            wr_req_q <= bus.ram_write_req;
            if (bus.ram_write_req) begin
                wr_addr_q <= bus.ram_write_addr;
                wr_be_q   <= bus.ram_write_be;
                wr_data_q <= bus.ram_write_data;
            end
        end
    end

    // Commit the write stage lane by lane; reset clears wr_req_q so a captured write is dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_req_q && wr_be_q[i]) begin
                mem[wr_addr_q][i*BYTE_W +: BYTE_W] <= wr_data_q[i*BYTE_W +: BYTE_W];
            end
        end
    end

    // Array word at the read address, with enabled lanes of a colliding pending write forwarded.
    always_comb begin
        rd_word = mem[bus.ram_read_addr];
        if (BYPASS != 0 && wr_req_q && (wr_addr_q == bus.ram_read_addr)) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be_q[i]) begin
                    rd_word[i*BYTE_W +: BYTE_W] = wr_data_q[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // First read stage: data only moves when a read is requested, so it holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= bus.ram_read_req;
            if (bus.ram_read_req) begin
                rd_data_q <= rd_word;
            end
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic             rd_valid_q2;
        logic [WIDTH-1:0] rd_data_q2;

        // Optional output register adding one cycle to both data and valid.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_valid_q2 <= 1'b0;
                rd_data_q2  <= '0;
            end else begin
                rd_valid_q2 <= rd_valid_q;
                if (rd_valid_q) begin
                    rd_data_q2 <= rd_data_q;
                end
            end
        end

        assign bus.ram_read_valid = rd_valid_q2;
        assign bus.ram_read_data  = rd_data_q2;
    end else begin : g_no_out_reg
        assign bus.ram_read_valid = rd_valid_q;
        assign bus.ram_read_data  = rd_data_q;
    end
endmodule

// File: tb/tb_model_dual_ram_be.sv
// Bench for model_dual_ram_be: three instances (bypass/latency 1, no-bypass/latency 1,
// bypass/latency 2) share one stimulus stream and are checked against a word-level model.
module tb_model_dual_ram_be;
    logic        clk;
    logic        rst_n;
    logic        w_req;
    logic [3:0]  w_addr;
    logic [3:0]  w_be;
    logic [31:0] w_data;
    logic        r_req;
    logic [3:0]  r_addr;

    int nvec = 0;
    int nerr = 0;

    model_dual_ram_be_if #(.WIDTH(32), .DEPTH_LOG(4), .BYTE_W(8)) if0 ();
    model_dual_ram_be_if #(.WIDTH(32), .DEPTH_LOG(4), .BYTE_W(8)) if1 ();
    model_dual_ram_be_if #(.WIDTH(32), .DEPTH_LOG(4), .BYTE_W(8)) if2 ();

    assign if0.ram_write_req  = w_req;
    assign if0.ram_write_addr = w_addr;
    assign if0.ram_write_be   = w_be;
    assign if0.ram_write_data = w_data;
    assign if0.ram_read_req   = r_req;
    assign if0.ram_read_addr  = r_addr;
    assign if1.ram_write_req  = w_req;
    assign if1.ram_write_addr = w_addr;
    assign if1.ram_write_be   = w_be;
    assign if1.ram_write_data = w_data;
    assign if1.ram_read_req   = r_req;
    assign if1.ram_read_addr  = r_addr;
    assign if2.ram_write_req  = w_req;
    assign if2.ram_write_addr = w_addr;
    assign if2.ram_write_be   = w_be;
    assign if2.ram_write_data = w_data;
    assign if2.ram_read_req   = r_req;
    assign if2.ram_read_addr  = r_addr;

    model_dual_ram_be #(.WIDTH(32), .DEPTH_LOG(4), .BYTE_W(8), .OUT_REG(0), .BYPASS(1))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    model_dual_ram_be #(.WIDTH(32), .DEPTH_LOG(4), .BYTE_W(8), .OUT_REG(0), .BYPASS(0))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    model_dual_ram_be #(.WIDTH(32), .DEPTH_LOG(4), .BYTE_W(8), .OUT_REG(1), .BYPASS(1))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    logic        got_v [3];
    logic [31:0] got_d [3];
    assign got_v[0] = if0.ram_read_valid;
    assign got_d[0] = if0.ram_read_data;
    assign got_v[1] = if1.ram_read_valid;
    assign got_d[1] = if1.ram_read_data;
    assign got_v[2] = if2.ram_read_valid;
    assign got_d[2] = if2.ram_read_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Reference model: mem_new holds every write captured before the current edge,
    // mem_old every write captured at least two edges back. A read sees mem_new with
    // forwarding and mem_old without it.
    typedef struct {
        int          rd_cyc;
        logic [31:0] byp;
        logic [31:0] nobyp;
    } rd_t;

    logic [31:0] mem_new [16];
    logic [31:0] mem_old [16];
    rd_t         rdq [$];
    logic [31:0] held [3];
    int          cyc = 0;
    bit          model_on = 0;
    int          lat [3] = '{1, 1, 2};

    // Model the RAM at word level on each active edge.
    always @(posedge clk) begin
        if (rst_n) begin
            cyc++;
            if (r_req) rdq.push_back('{cyc, mem_new[r_addr], mem_old[r_addr]});
            mem_old = mem_new;
            if (w_req) begin
                for (int i = 0; i < 4; i++) begin
                    if (w_be[i]) mem_new[w_addr][i*8 +: 8] = w_data[i*8 +: 8];
                end
            end
        end
    end

    // Reset drops the write that has not yet reached the array and all pending reads.
    always @(negedge rst_n) begin
        mem_new = mem_old;
        rdq.delete();
    end

    // Compare every instance against the model once per cycle.
    always @(negedge clk) begin
        if (model_on) begin
            for (int k = 0; k < 3; k++) begin
                logic        ev;
                logic [31:0] ed;
                ev = 1'b0;
                ed = held[k];
                if (!rst_n) begin
                    ed = 32'h0;
                end else begin
                    foreach (rdq[j]) begin
                        if (rdq[j].rd_cyc + lat[k] - 1 == cyc) begin
                            ev = 1'b1;
                            ed = (k == 1) ? rdq[j].nobyp : rdq[j].byp;
                        end
                    end
                end
                chk($sformatf("model dut%0d valid", k), {31'h0, got_v[k]}, {31'h0, ev});
                chk($sformatf("model dut%0d data", k), got_d[k], ed);
                held[k] = ed;
            end
            while (rdq.size() > 0 && rdq[0].rd_cyc < cyc - 1) void'(rdq.pop_front());
        end
    end

    task automatic step(input logic wq, input logic [3:0] wa, input logic [3:0] be,
                        input logic [31:0] wd, input logic rq, input logic [3:0] ra);
        w_req  = wq;
        w_addr = wa;
        w_be   = be;
        w_data = wd;
        r_req  = rq;
        r_addr = ra;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 4'd0, 4'd0, 32'h0, 1'b0, 4'd0);
    endtask

    typedef struct {
        logic        wq;
        logic [3:0]  wa;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        rq;
        logic [3:0]  ra;
        logic        ck;
        logic        ev;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [$];

    initial begin
        held[0] = 32'h0;
        held[1] = 32'h0;
        held[2] = 32'h0;
        rst_n  = 1'b0;
        w_req  = 1'b0;
        w_addr = 4'd0;
        w_be   = 4'd0;
        w_data = 32'h0;
        r_req  = 1'b0;
        r_addr = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset dut%0d valid", k), {31'h0, got_v[k]}, 32'h0);
            chk($sformatf("reset dut%0d data", k), got_d[k], 32'h0);
        end
        rst_n = 1'b1;
        model_on = 1;

        for (int a = 0; a < 16; a++) step(1'b1, a[3:0], 4'hF, 32'h0, 1'b0, 4'd0);
        idle();

        // wq wa be wd rq ra | ck ev exp(bypass) exp(no bypass)
        tbl.push_back('{1'b1, 4'd3,  4'hF, 32'hDEADBEEF, 1'b0, 4'd0,  1'b1, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd3,  1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  1'b1, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 4'd5,  4'hF, 32'h11223344, 1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 4'd5,  4'h5, 32'hAABBCCDD, 1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd5,  1'b1, 1'b1, 32'h11BB33DD, 32'h11BB33DD});
        tbl.push_back('{1'b1, 4'd5,  4'h0, 32'hFFFFFFFF, 1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd5,  1'b1, 1'b1, 32'h11BB33DD, 32'h11BB33DD});
        tbl.push_back('{1'b1, 4'd7,  4'hF, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 4'd7,  4'hF, 32'hCAFEF00D, 1'b1, 4'd7,  1'b1, 1'b1, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd7,  1'b1, 1'b1, 32'hCAFEF00D, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd7,  1'b1, 1'b1, 32'hCAFEF00D, 32'hCAFEF00D});
        tbl.push_back('{1'b1, 4'd0,  4'hF, 32'hA5A50000, 1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b1, 4'd15, 4'hF, 32'h5A5AFFFF, 1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  1'b0, 1'b0, 32'h0, 32'h0});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd0,  1'b1, 1'b1, 32'hA5A50000, 32'hA5A50000});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b1, 4'd15, 1'b1, 1'b1, 32'h5A5AFFFF, 32'h5A5AFFFF});
        tbl.push_back('{1'b0, 4'd0,  4'h0, 32'h0,        1'b0, 4'd0,  1'b1, 1'b0, 32'h0, 32'h0});

        foreach (tbl[i]) begin
            step(tbl[i].wq, tbl[i].wa, tbl[i].be, tbl[i].wd, tbl[i].rq, tbl[i].ra);
            if (tbl[i].ck) begin
                chk($sformatf("vec%0d dut0 valid", i), {31'h0, got_v[0]}, {31'h0, tbl[i].ev});
                chk($sformatf("vec%0d dut1 valid", i), {31'h0, got_v[1]}, {31'h0, tbl[i].ev});
                if (tbl[i].ev) begin
                    chk($sformatf("vec%0d dut0 data", i), got_d[0], tbl[i].e0);
                    chk($sformatf("vec%0d dut1 data", i), got_d[1], tbl[i].e1);
                end
            end
        end

        // Latency-2 instance: three back-to-back reads.
        step(1'b1, 4'd0, 4'hF, 32'h10, 1'b0, 4'd0);
        step(1'b1, 4'd1, 4'hF, 32'h11, 1'b0, 4'd0);
        step(1'b1, 4'd2, 4'hF, 32'h12, 1'b0, 4'd0);
        idle();
        idle();
        step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd0);
        chk("oreg cyc0 valid", {31'h0, got_v[2]}, 32'h0);
        step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd1);
        chk("oreg cyc1 valid", {31'h0, got_v[2]}, 32'h1);
        chk("oreg cyc1 data", got_d[2], 32'h10);
        step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd2);
        chk("oreg cyc2 valid", {31'h0, got_v[2]}, 32'h1);
        chk("oreg cyc2 data", got_d[2], 32'h11);
        idle();
        chk("oreg cyc3 valid", {31'h0, got_v[2]}, 32'h1);
        chk("oreg cyc3 data", got_d[2], 32'h12);
        idle();
        chk("oreg cyc4 valid", {31'h0, got_v[2]}, 32'h0);
        chk("oreg cyc4 hold", got_d[2], 32'h12);

        // Reset right after a write is captured: the write must be lost.
        step(1'b1, 4'd9, 4'hF, 32'h77, 1'b0, 4'd0);
        idle();
        idle();
        w_req  = 1'b1;
        w_addr = 4'd9;
        w_be   = 4'hF;
        w_data = 32'h55;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        w_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("midrst dut%0d valid", k), {31'h0, got_v[k]}, 32'h0);
                chk($sformatf("midrst dut%0d data", k), got_d[k], 32'h0);
            end
        end
        rst_n = 1'b1;
        step(1'b0, 4'd0, 4'h0, 32'h0, 1'b1, 4'd9);
        chk("after rst dut0 data", got_d[0], 32'h77);
        chk("after rst dut1 data", got_d[1], 32'h77);
        idle();
        chk("after rst dut2 data", got_d[2], 32'h77);

        // Random traffic, biased towards read/write address collisions.
        for (int n = 0; n < 400; n++) begin
            logic [3:0] wa;
            logic [3:0] ra;
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 1) == 1) ? w_addr : 4'($urandom_range(0, 15));
            step(1'($urandom_range(0, 1)), wa, 4'($urandom_range(0, 15)), $urandom,
                 1'($urandom_range(0, 1)), ra);
        end
        idle();
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
